keypad_matrix_emulator: RTL and testbench
=========================================

Name: keypad_matrix_emulator

Overview:
- Drives a 4x4 keypad matrix from command inputs, for the keypad scan/decode path to read.
- Watches the active-low row strobes from the row scanner.
- Drives active-low column lines exactly as a physical key closure would.
- Used for on-board self-test and bench stimulus, so keypad scan, buffer and display can run without a human pressing keys.

Parameters:
- HOLD_SCANS, 4: full row sweeps the key stays closed after bounce ends (legal 1..255).
- GAP_SCANS, 2: full row sweeps the key stays open after release before done (legal 1..255).
- BOUNCE_CYC, 0: clk cycles of contact chatter at press start (0 = clean press; legal 0..65535).

Ports:
- clk, in, 1: single clock; same clock as the row scanner's strobe domain.
- rst, in, 1: synchronous, active-high reset.
- kr_sel, in, 4: row strobes from the scanner; active-low; bit r low means row r is selected.
- cmd_valid, in, 1: key command offered.
- cmd_code, in, 4: key to press. [3:2] = row index, [1:0] = column index.
- cmd_ready, out, 1: high when a command can be accepted.
- kc_sel, out, 4: column lines back to the decoder; active-low, 1111 when no contact.
- busy, out, 1: command in progress.
- done, out, 1: one-cycle pulse when the command's release gap completes.
- contact, out, 1: current modelled switch closure (debug).

Behaviour:
- Reset values:
  - state = IDLE
  - cmd_ready = 1, busy = 0, done = 0, contact = 0
  - kc_sel = 1111
  - internal counters and latched code = 0
- kc_sel is combinational from the registered contact/code plus kr_sel:
  - kc_sel[c] = ~(contact & (c == code[1:0]) & ~kr_sel[code[3:2]])
  - So if several rows are low at once, only the target row bit matters, as on a real matrix.
  - If kr_sel = 1111, kc_sel = 1111.
- Sweep event:
  - prev_kr is a register of kr_sel.
  - sweep = (kr_sel == 1110) & (prev_kr != 1110), i.e. arrival of the row-0 strobe.
  - A strobe held for many clk cycles counts once.
- Handshake:
  - Accept when cmd_valid & cmd_ready on a rising edge. cmd_code is latched on that edge.
  - cmd_ready = (state == IDLE).
  - cmd_valid while busy is ignored; nothing is queued.
- FSM:
  - IDLE:
    - On accept: go to BOUNCE if BOUNCE_CYC > 0, else go to PRESS.
    - contact = 0, busy = 0.
  - BOUNCE:
    - contact = 1 on the first cycle, then toggles every clk.
    - Counts BOUNCE_CYC cycles, then goes to PRESS.
    - busy = 1.
  - PRESS:
    - contact = 1.
    - Hold counter increments on each sweep.
    - Leaves to RELEASE on the cycle the counter reaches HOLD_SCANS.
  - RELEASE:
    - contact = 0.
    - Gap counter increments on each sweep.
    - On reaching GAP_SCANS: go to IDLE and pulse done for that one cycle.
    - cmd_ready rises on the following cycle.
- Latency:
  - contact rises 1 cycle after accept.
  - Total busy time depends only on the sweep count of the incoming strobes, not on clk count (except the bounce phase).
- Boundaries:
  - Sweep on the same cycle as entry to PRESS/RELEASE is not counted. Counting starts the cycle after entry.
  - Counters are 8-bit for scans and 16-bit for bounce, and saturate (never wrap).
  - kr_sel frozen (scanner stopped): the block stays in PRESS/RELEASE indefinitely. No timeout.
  - rst asserted mid-command: the next edge forces IDLE and contact = 0, so kc_sel = 1111 in the same cycle. done is not pulsed.
  - done and a new accept cannot coincide, because ready is low in RELEASE.

Test Plan:
1. Clean press, scanner cycling 1110→1101→1011→0111 every 4 clk, cmd_code = 0110:
   - kc_sel = 1011 only while kr_sel = 1101.
   - kc_sel = 1111 otherwise.
   - done after exactly 4 hold sweeps + 2 gap sweeps.
2. Bounce with BOUNCE_CYC = 5, cmd_code = 0000, kr_sel held at 1110:
   - contact follows 1,0,1,0,1 then stays 1.
   - No sweep is counted while kr_sel is held.
3. kr_sel = 0000 (all rows low), cmd_code = 1111 in PRESS:
   - kc_sel = 0111.
4. cmd_valid held high while busy, with codes changing:
   - Only the first code is ever seen on kc_sel.
   - A second accept occurs the cycle after done.
5. rst pulsed one cycle mid-PRESS:
   - Next cycle: kc_sel = 1111, cmd_ready = 1, busy = 0.
   - No done pulse.
6. Scanner stopped at kr_sel = 1101 during PRESS for 1000 clk:
   - busy stays 1 and no done.
   - Resuming the scan completes the command normally.

Source files
------------

// File: rtl/keypad_matrix_emulator_if.sv
// Command and matrix lines of the keypad emulator.
// The master side is the self-test sequencer and row scanner; the slave side is the emulator.
interface keypad_matrix_emulator_if;
  logic [3:0] kr_sel;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic       cmd_ready;
  logic [3:0] kc_sel;
  logic       busy;
  logic       done;
  logic       contact;

  modport master (
    output kr_sel, cmd_valid, cmd_code,
    input  cmd_ready, kc_sel, busy, done, contact
  );

  modport slave (
    input  kr_sel, cmd_valid, cmd_code,
    output cmd_ready, kc_sel, busy, done, contact
  );
endinterface

// File: rtl/keypad_matrix_emulator.sv
// Emulates a single key closure on a 4x4 active-low matrix: optional contact chatter,
// then hold and release phases timed in full row sweeps of the external scanner.
module kme_col_drv (
  input  logic contact,
  input  logic hit,
  input  logic row_on,
  output logic kc
);
  assign kc = ~(contact & hit & row_on);
endmodule

module keypad_matrix_emulator #(
  parameter int HOLD_SCANS = 4,
  parameter int GAP_SCANS  = 2,
  parameter int BOUNCE_CYC = 0
) (
  input logic                      clk,
  input logic                      rst,
  keypad_matrix_emulator_if.slave  kif
);
  typedef enum logic [1:0] {IDLE, BOUNCE, PRESS, RELEASE} state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_t;

  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_SCANS - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_SCANS - 1);
  localparam logic [15:0] BNC_LAST  = 16'((BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : 0);

  state_t      state_q, state_d;
  key_t        code_q, code_d;
  logic        contact_q, contact_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] bnc_q, bnc_d;
  logic [3:0]  prev_kr;
  logic        sweep;
  logic        accept;
  logic        done_c;
  logic [3:0]  kc;

  // A sweep is the arrival of the row-0 strobe; a long-held strobe counts once.
  assign sweep  = (kif.kr_sel == 4'b1110) && (prev_kr != 4'b1110);
  assign accept = kif.cmd_valid && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= '0;
      contact_q <= 1'b0;
      hold_q    <= '0;
      gap_q     <= '0;
      bnc_q     <= '0;
      prev_kr   <= 4'hF;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      contact_q <= contact_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      bnc_q     <= bnc_d;
      prev_kr   <= kif.kr_sel;
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    contact_d = contact_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    bnc_d     = bnc_q;
    done_c    = 1'b0;
    case (state_q)
      IDLE: begin
        contact_d = 1'b0;
        if (accept) begin
          code_d    = kif.cmd_code;
          hold_d    = '0;
          gap_d     = '0;
          bnc_d     = '0;
          contact_d = 1'b1;
          state_d   = (BOUNCE_CYC > 0) ? BOUNCE : PRESS;
        end
      end
      BOUNCE: begin
        bnc_d = (bnc_q == 16'hFFFF) ? bnc_q : bnc_q + 16'd1;
        // The last chatter cycle hands over to a solid closure.
        if (bnc_q >= BNC_LAST) begin
          state_d   = PRESS;
          contact_d = 1'b1;
        end else begin
          contact_d = ~contact_q;
        end
      end
      PRESS: begin
        contact_d = 1'b1;
        if (sweep) begin
          hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
          if (hold_q >= HOLD_LAST) begin
            state_d   = RELEASE;
            contact_d = 1'b0;
            gap_d     = '0;
          end
        end
      end
      RELEASE: begin
        contact_d = 1'b0;
        if (sweep) begin
          gap_d = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
          if (gap_q >= GAP_LAST) begin
            state_d = IDLE;
            done_c  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the target row strobe matters, so multiple low rows behave like a real matrix.
  for (genvar c = 0; c < 4; c++) begin : g_col
    kme_col_drv u_col (
      .contact (contact_q),
      .hit     (code_q.col == 2'(c)),
      .row_on  (~kif.kr_sel[code_q.row]),
      .kc      (kc[c])
    );
  end

  assign kif.kc_sel    = kc;
  assign kif.cmd_ready = (state_q == IDLE);
  assign kif.busy      = (state_q != IDLE);
  assign kif.done      = done_c & ~rst;
  assign kif.contact   = contact_q;
endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench: clean press, bounce, multi-row strobes, back-to-back commands,
// mid-command reset and a stalled scanner.
module tb_keypad_matrix_emulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  bit   scan_on = 0;
  int   sc_row = 3;
  int   sc_div = 3;
  bit   arrived = 0;

  keypad_matrix_emulator_if m ();
  keypad_matrix_emulator_if b ();

  keypad_matrix_emulator #(.HOLD_SCANS(4), .GAP_SCANS(2), .BOUNCE_CYC(0)) u_dut (
    .clk (clk), .rst (rst), .kif (m)
  );

  keypad_matrix_emulator #(.HOLD_SCANS(4), .GAP_SCANS(2), .BOUNCE_CYC(5)) u_bnc (
    .clk (clk), .rst (rst), .kif (b)
  );

  always #5 clk = ~clk;

  // One clock: drive 1 ns after the edge (scanner advances every 4 clk), check 4 ns after.
  task automatic step();
    logic [3:0] old;
    @(posedge clk);
    #1;
    arrived = 0;
    if (scan_on) begin
      old = m.kr_sel;
      sc_div++;
      if (sc_div == 4) begin
        sc_div = 0;
        sc_row = (sc_row + 1) % 4;
      end
      m.kr_sel = 4'(~(4'b0001 << sc_row));
      arrived = (m.kr_sel == 4'b1110) && (old != 4'b1110);
    end
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    m.kr_sel = 4'b0000; m.cmd_valid = 0; m.cmd_code = 4'b0000;
    b.kr_sel = 4'b1110; b.cmd_valid = 0; b.cmd_code = 4'b0000;
    rst = 1'b1;
    repeat (3) step();
    total++; if (m.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", m.cmd_ready); end
    total++; if (m.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", m.busy); end
    total++; if (m.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", m.done); end
    total++; if (m.contact !== 1'b0) begin bad++; $display("FAIL rst_contact got=%b exp=0", m.contact); end
    total++; if (m.kc_sel !== 4'b1111) begin bad++; $display("FAIL rst_kc got=%b exp=1111", m.kc_sel); end
    rst = 1'b0;
    m.kr_sel = 4'b1111;
    step();
  endtask

  task automatic test_bounce();
    bit exp_c [6] = '{1, 0, 1, 0, 1, 1};
    bit ok;
    step();
    b.cmd_code = 4'b0000; b.cmd_valid = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      b.cmd_valid = 0;
      total++; if (b.contact !== exp_c[i]) begin bad++; $display("FAIL bnc_contact[%0d] got=%b exp=%b", i, b.contact, exp_c[i]); end
      total++; if (b.kc_sel !== (exp_c[i] ? 4'b1110 : 4'b1111)) begin bad++; $display("FAIL bnc_kc[%0d] got=%b", i, b.kc_sel); end
    end
    ok = 1;
    repeat (20) begin
      step();
      if (b.contact !== 1'b1 || b.busy !== 1'b1 || b.done !== 1'b0) ok = 0;
    end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bnc_held_no_sweep got=0 exp=1"); end
    for (int k = 0; k < 6; k++) begin
      b.kr_sel = 4'b1101;
      step();
      b.kr_sel = 4'b1110;
      #1;
      total++; if (b.done !== (k == 5)) begin bad++; $display("FAIL bnc_done[%0d] got=%b exp=%b", k, b.done, (k == 5)); end
      step();
      total++; if (b.contact !== (k < 3)) begin bad++; $display("FAIL bnc_phase[%0d] got=%b exp=%b", k, b.contact, (k < 3)); end
    end
    total++; if (b.busy !== 1'b0 || b.cmd_ready !== 1'b1) begin bad++; $display("FAIL bnc_end busy=%b ready=%b exp 0/1", b.busy, b.cmd_ready); end
  endtask

  task automatic test_clean_press();
    int n = 0;
    bit fin = 0;
    bit exp_c;
    logic [3:0] exp_kc;
    scan_on = 1;
    do step(); while (arrived);
    m.cmd_code = 4'b0110; m.cmd_valid = 1;
    for (int i = 0; i < 300 && !fin; i++) begin
      step();
      m.cmd_valid = 0;
      if (arrived) n++;
      exp_c  = ((n - int'(arrived)) < 4);
      exp_kc = (exp_c && m.kr_sel == 4'b1101) ? 4'b1011 : 4'b1111;
      fin    = (n == 6) && arrived;
      total++; if (m.kc_sel !== exp_kc) begin bad++; $display("FAIL clean_kc cyc=%0d got=%b exp=%b", i, m.kc_sel, exp_kc); end
      total++; if (m.contact !== exp_c) begin bad++; $display("FAIL clean_contact cyc=%0d got=%b exp=%b", i, m.contact, exp_c); end
      total++; if (m.done !== fin) begin bad++; $display("FAIL clean_done cyc=%0d got=%b exp=%b", i, m.done, fin); end
      total++; if (m.busy !== 1'b1) begin bad++; $display("FAIL clean_busy cyc=%0d got=%b exp=1", i, m.busy); end
    end
    step();
    total++; if (m.cmd_ready !== 1'b1 || m.busy !== 1'b0) begin bad++; $display("FAIL clean_end ready=%b busy=%b exp 1/0", m.cmd_ready, m.busy); end
    total++; if (m.kc_sel !== 4'b1111) begin bad++; $display("FAIL clean_end_kc got=%b exp=1111", m.kc_sel); end
  endtask

  task automatic test_all_rows();
    logic [3:0] kr [4] = '{4'b0000, 4'b0111, 4'b1000, 4'b1111};
    logic [3:0] ek [4] = '{4'b0111, 4'b0111, 4'b1111, 4'b1111};
    scan_on = 0;
    m.kr_sel = 4'b1111;
    m.cmd_code = 4'b1111; m.cmd_valid = 1;
    step();
    m.cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      m.kr_sel = kr[i];
      #1;
      total++; if (m.kc_sel !== ek[i]) begin bad++; $display("FAIL rows_kc kr=%b got=%b exp=%b", kr[i], m.kc_sel, ek[i]); end
    end
    do_reset();
  endtask

  task automatic test_rst_mid();
    scan_on = 0;
    m.kr_sel = 4'b1011;
    m.cmd_code = 4'b1000; m.cmd_valid = 1;
    step();
    m.cmd_valid = 0;
    total++; if (m.busy !== 1'b1 || m.kc_sel !== 4'b1110) begin bad++; $display("FAIL rmid_press busy=%b kc=%b exp 1/1110", m.busy, m.kc_sel); end
    step();
    rst = 1'b1;
    #1;
    total++; if (m.done !== 1'b0) begin bad++; $display("FAIL rmid_done_in_rst got=%b exp=0", m.done); end
    step();
    rst = 1'b0;
    total++; if (m.kc_sel !== 4'b1111) begin bad++; $display("FAIL rmid_kc got=%b exp=1111", m.kc_sel); end
    total++; if (m.cmd_ready !== 1'b1 || m.busy !== 1'b0) begin bad++; $display("FAIL rmid_ready ready=%b busy=%b exp 1/0", m.cmd_ready, m.busy); end
    total++; if (m.done !== 1'b0 || m.contact !== 1'b0) begin bad++; $display("FAIL rmid_done done=%b contact=%b exp 0/0", m.done, m.contact); end
    m.kr_sel = 4'b1111;
    step();
  endtask

  task automatic test_stall();
    int n = 0;
    bit ok = 1;
    bit fin = 0;
    bit seen = 0;
    scan_on = 1;
    do step(); while (arrived);
    m.cmd_code = 4'b0110; m.cmd_valid = 1;
    for (int i = 0; i < 100 && !(n == 1 && sc_row == 1); i++) begin
      step();
      m.cmd_valid = 0;
      if (arrived) n++;
    end
    scan_on = 0;
    repeat (1000) begin
      step();
      if (m.busy !== 1'b1 || m.done !== 1'b0) ok = 0;
    end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_hold got=0 exp=1"); end
    total++; if (m.kc_sel !== 4'b1011) begin bad++; $display("FAIL stall_kc got=%b exp=1011", m.kc_sel); end
    scan_on = 1;
    for (int i = 0; i < 300 && !fin; i++) begin
      step();
      if (arrived) n++;
      fin = (n == 6) && arrived;
      if (m.done === 1'b1) seen = 1;
      total++; if (m.done !== fin) begin bad++; $display("FAIL stall_done cyc=%0d got=%b exp=%b", i, m.done, fin); end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL stall_resume_done got=0 exp=1"); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] junk [3] = '{4'b1010, 4'b1111, 4'b0000};
    int n = 0;
    bit fin = 0;
    bit hit = 0;
    logic [3:0] exp_kc;
    scan_on = 1;
    do step(); while (arrived);
    m.cmd_code = 4'b0101; m.cmd_valid = 1;
    for (int i = 0; i < 300 && !fin; i++) begin
      step();
      if (arrived) n++;
      fin = (n == 6) && arrived;
      m.cmd_code = fin ? 4'b0011 : junk[i % 3];
      exp_kc = ((n - int'(arrived)) < 4 && m.kr_sel == 4'b1101) ? 4'b1101 : 4'b1111;
      total++; if (m.kc_sel !== exp_kc) begin bad++; $display("FAIL b2b_kc cyc=%0d got=%b exp=%b", i, m.kc_sel, exp_kc); end
      total++; if (m.done !== fin) begin bad++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", i, m.done, fin); end
    end
    step();
    total++; if (m.cmd_ready !== 1'b1 || m.busy !== 1'b0) begin bad++; $display("FAIL b2b_gap ready=%b busy=%b exp 1/0", m.cmd_ready, m.busy); end
    step();
    m.cmd_valid = 0;
    total++; if (m.busy !== 1'b1 || m.contact !== 1'b1) begin bad++; $display("FAIL b2b_accept2 busy=%b contact=%b exp 1/1", m.busy, m.contact); end
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m.kr_sel == 4'b1110) hit = 1;
      else step();
    end
    total++; if (m.kc_sel !== 4'b0111) begin bad++; $display("FAIL b2b_code2_kc got=%b exp=0111", m.kc_sel); end
    scan_on = 0;
    m.kr_sel = 4'b1111;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_all_rows();
    test_rst_mid();
    test_stall();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
